pipeline_stage_elastic: RTL and testbench
=========================================

# pipeline_stage_elastic

Parametrised, elastic pipeline stage register that generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries an arbitrary data payload plus a separately flushable control field, and uses a valid/ready handshake instead of a single write-enable. An optional skid entry breaks the combinational ready path. Flush turns in-flight entries into bubbles, and a saturating counter reports back-pressure stall cycles to the core's performance counters.

## Interface
- DATA_W, 64: payload width (addresses, operands, PC); not cleared on flush.
- CTRL_W, 8: control field width (RegWrite, MemRead, MemWrite, Branch, ...); zeroed on flush and reset.
- SKID, 1: 1 = two-entry skid buffer, registered in_ready; 0 = single register, combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous kill of all held entries and of the same-cycle input.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  presented payload.
- out_ctrl  out  CTRL_W  presented control; all zero whenever out_valid=0.
- stall_cnt  out  CNT_W  saturating count of out_valid & ~out_ready cycles.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Entries leave in strict arrival order. No entry is duplicated or dropped except by flush.
- SKID=1 uses main register M and skid register S. States:
  - EMPTY to ONE: input transfer.
  - ONE stays ONE: input and output transfer in the same cycle; M is overwritten by the new input.
  - ONE to EMPTY: output transfer, no input.
  - ONE to TWO: input, no output; the new entry goes to S.
  - TWO to ONE: output transfer; S moves to M.
  - TWO, no input: in_ready=0 in TWO, so no input can arrive.
- in_ready = ~S_valid, driven from a flop. out_valid = M_valid.
- SKID=0: single register M, with in_ready = ~M_valid | out_ready.
- Flush, with priority over everything except reset:
  - Next cycle: M_valid=0, S_valid=0, M_ctrl=0, S_ctrl=0.
  - A same-cycle input transfer is discarded.
  - A same-cycle output transfer still completes, because downstream already sampled it.
  - Data registers keep their values.
- Ctrl masking: out_ctrl = M_valid ? M_ctrl : 0. This guarantees a bubble never asserts a write enable downstream.
- Stall counter:
  - Increments each cycle out_valid & ~out_ready holds, saturating at 2^CNT_W-1.
  - stall_clr has priority over the increment: the counter reads 0 next cycle.
  - flush does not affect stall_cnt.
- Reset, which overrides flush and stall_clr:
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - S cleared; in_ready=1 (SKID=1) or 1 (SKID=0, M empty).
  - Reset mid-stream discards all held entries with no output transfer.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 entry per cycle with out_ready held high, in both modes.
- SKID=1 has no combinational path from out_ready to in_ready. After back-pressure, in_ready rises the cycle after the output transfer that drains S.
- SKID=0 has a combinational path from out_ready to in_ready.
- in_data/in_ctrl are sampled only on a transfer edge. out_data/out_ctrl stay stable while out_valid & ~out_ready.
- stall_cnt updates 1 cycle after the stall cycle it counts.

## Test plan
- Streaming: SKID=1, out_ready=1, feed 0x10..0x1F on consecutive cycles.
  - Expect out_data 0x10..0x1F, each exactly 1 cycle after input, with in_ready constantly 1.
- Back-pressure: send A=0x1, B=0x2 and hold out_ready=0.
  - Expect state TWO, in_ready=0, out_data=0x1 stable.
  - Raise out_ready: outputs 0x1 then 0x2; in_ready=1 the cycle after 0x1 leaves.
- Flush in TWO with in_valid=1 and in_ctrl=0xFF.
  - Next cycle: out_valid=0, out_ctrl=0x00, in_ready=1.
  - The flushed and discarded entries never appear.
- Stall counter: hold out_valid & ~out_ready for 5 cycles, expect stall_cnt=5.
  - stall_clr on the same cycle as a stall cycle gives 0.
  - With CNT_W=4, 20 stall cycles gives 15.
- Reset mid-operation: reset asserted in TWO together with flush and stall_clr.
  - Next cycle: all outputs 0, in_ready=1, stall_cnt=0.
- SKID=0: in_valid=1 continuously, toggle out_ready each cycle.
  - in_ready must follow (~out_valid | out_ready) in the same cycle.
  - Entries emerge in order with none lost.

Source files
------------

// File: rtl/pipeline_stage_elastic.sv
// Elastic valid/ready pipeline stage register with optional two-entry skid buffer,
// flushable control field (masked to zero on bubbles) and saturating stall counter.
module pipeline_stage_elastic #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              m_valid_s;
    logic [DATA_W-1:0] m_data_q;
    logic [CTRL_W-1:0] m_ctrl_q;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = m_valid_s & out_ready;

    assign out_valid = m_valid_s;
    assign out_data  = m_data_q;
    // A bubble must never present a live write enable downstream.
    assign out_ctrl  = m_valid_s ? m_ctrl_q : {CTRL_W{1'b0}};
    assign stall_cnt = stall_cnt_q;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_TWO   = 2'd2
            } state_e;

            state_e            state_q;
            state_e            state_d;
            logic              in_ready_q;
            logic              in_ready_d;
            logic [DATA_W-1:0] m_data_d;
            logic [CTRL_W-1:0] m_ctrl_d;
            logic [DATA_W-1:0] s_data_q;
            logic [DATA_W-1:0] s_data_d;
            logic [CTRL_W-1:0] s_ctrl_q;
            logic [CTRL_W-1:0] s_ctrl_d;

            assign m_valid_s = (state_q != ST_EMPTY);
            assign in_ready  = in_ready_q;

            // State and storage registers of the two-entry buffer.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                    m_data_q   <= {DATA_W{1'b0}};
                    m_ctrl_q   <= {CTRL_W{1'b0}};
                    s_data_q   <= {DATA_W{1'b0}};
                    s_ctrl_q   <= {CTRL_W{1'b0}};
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= in_ready_d;
                    m_data_q   <= m_data_d;
                    m_ctrl_q   <= m_ctrl_d;
                    s_data_q   <= s_data_d;
                    s_ctrl_q   <= s_ctrl_d;
                end
            end

            // Next-state: occupancy transitions, then flush override.
            always_comb begin
                state_d  = state_q;
                m_data_d = m_data_q;
                m_ctrl_d = m_ctrl_q;
                s_data_d = s_data_q;
                s_ctrl_d = s_ctrl_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (in_xfer_s) begin
                            state_d  = ST_ONE;
                            m_data_d = in_data;
                            m_ctrl_d = in_ctrl;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_ONE: begin
                        if (in_xfer_s && out_xfer_s) begin
                            m_data_d = in_data;
                            m_ctrl_d = in_ctrl;
                        end else if (in_xfer_s) begin
                            state_d  = ST_TWO;
                            s_data_d = in_data;
                            s_ctrl_d = in_ctrl;
                        end else if (out_xfer_s) begin
                            state_d = ST_EMPTY;
                        end else begin
                            state_d = ST_ONE;
                        end
                    end
                    ST_TWO: begin
                        if (out_xfer_s) begin
                            state_d  = ST_ONE;
                            m_data_d = s_data_q;
                            m_ctrl_d = s_ctrl_q;
                        end else begin
                            state_d = ST_TWO;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
                // Flush kills everything held and the same-cycle input; payloads stay put.
                if (flush) begin
                    state_d  = ST_EMPTY;
                    m_data_d = m_data_q;
                    s_data_d = s_data_q;
                    m_ctrl_d = {CTRL_W{1'b0}};
                    s_ctrl_d = {CTRL_W{1'b0}};
                end else begin
                    state_d = state_d;
                end
                in_ready_d = (state_d != ST_TWO);
            end
        end else begin : g_single
            logic              m_valid_q;
            logic              m_valid_d;
            logic [DATA_W-1:0] m_data_d;
            logic [CTRL_W-1:0] m_ctrl_d;

            assign m_valid_s = m_valid_q;
            assign in_ready  = ~m_valid_q | out_ready;

            // Single holding register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    m_valid_q <= 1'b0;
                    m_data_q  <= {DATA_W{1'b0}};
                    m_ctrl_q  <= {CTRL_W{1'b0}};
                end else begin
                    m_valid_q <= m_valid_d;
                    m_data_q  <= m_data_d;
                    m_ctrl_q  <= m_ctrl_d;
                end
            end

            // Next-state of the single register, flush first.
            always_comb begin
                m_valid_d = m_valid_q;
                m_data_d  = m_data_q;
                m_ctrl_d  = m_ctrl_q;
                if (flush) begin
                    m_valid_d = 1'b0;
                    m_ctrl_d  = {CTRL_W{1'b0}};
                end else if (in_xfer_s) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_data;
                    m_ctrl_d  = in_ctrl;
                end else if (out_xfer_s) begin
                    m_valid_d = 1'b0;
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
        end
    endgenerate

    // Stall counter next value: clear wins, increment saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (m_valid_s && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: directed vector table on the skid variant, then
// streaming, saturation and randomized traffic checked against a queue model of both variants.
module tb_pipeline_stage_elastic;

    logic        clk = 1'b0;
    logic        rst = 1'b1, fl = 1'b0, clr = 1'b0, iv = 1'b0, ordy = 1'b0;
    logic [63:0] d = 64'h0;
    logic [7:0]  c = 8'h0;

    logic        ir1, ov1, ir0, ov0;
    logic [63:0] od1, od0;
    logic [7:0]  oc1, oc0;
    logic [15:0] cnt1;
    logic [3:0]  cnt0;

    int nvec = 0;
    int nmis = 0;
    bit mon  = 1'b0;

    logic [71:0] mq [2][$];
    int          mcnt [2];
    int          cmax [2];

    always #5 clk = ~clk;

    pipeline_stage_elastic #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(ir1),
        .in_data(d), .in_ctrl(c), .out_valid(ov1), .out_ready(ordy),
        .out_data(od1), .out_ctrl(oc1), .stall_cnt(cnt1), .stall_clr(clr));

    pipeline_stage_elastic #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(ir0),
        .in_data(d), .in_ctrl(c), .out_valid(ov0), .out_ready(ordy),
        .out_data(od0), .out_ctrl(oc0), .stall_cnt(cnt0), .stall_clr(clr));

    typedef struct {
        logic rst, fl, clr, iv, ordy;
        logic [63:0] d;
        logic [7:0]  c;
        logic chk, ov, ir, dchk;
        logic [63:0] od;
        logic [7:0]  oc;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic r, logic f, logic cl, logic v, logic [63:0] dd,
                                logic [7:0] cc, logic rd, logic ck, logic eov,
                                logic [63:0] eod, logic [7:0] eoc, logic eir,
                                logic [15:0] ecnt, logic edchk);
        vec_t t;
        t.rst = r; t.fl = f; t.clr = cl; t.iv = v; t.d = dd; t.c = cc; t.ordy = rd;
        t.chk = ck; t.ov = eov; t.od = eod; t.oc = eoc; t.ir = eir; t.cnt = ecnt;
        t.dchk = edchk;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the queue model (state before the coming edge).
    task automatic mcheck();
        for (int k = 0; k < 2; k++) begin
            int          sz;
            logic        a_ov, a_ir, e_ir;
            logic [63:0] a_od;
            logic [7:0]  a_oc;
            logic [15:0] a_cnt;
            sz    = mq[k].size();
            a_ov  = (k == 1) ? ov1 : ov0;
            a_ir  = (k == 1) ? ir1 : ir0;
            a_od  = (k == 1) ? od1 : od0;
            a_oc  = (k == 1) ? oc1 : oc0;
            a_cnt = (k == 1) ? cnt1 : {12'h000, cnt0};
            e_ir  = (k == 1) ? (sz < 2) : (sz == 0 || ordy);
            chk($sformatf("m%0d_out_valid", k), {63'h0, a_ov}, {63'h0, (sz > 0)});
            chk($sformatf("m%0d_in_ready", k), {63'h0, a_ir}, {63'h0, e_ir});
            if (sz > 0) begin
                chk($sformatf("m%0d_out_data", k), a_od, mq[k][0][63:0]);
                chk($sformatf("m%0d_out_ctrl", k), {56'h0, a_oc}, {56'h0, mq[k][0][71:64]});
            end else begin
                chk($sformatf("m%0d_bubble_ctrl", k), {56'h0, a_oc}, 64'h0);
            end
            chk($sformatf("m%0d_stall_cnt", k), {48'h0, a_cnt}, 64'(mcnt[k]));
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic mupdate();
        for (int k = 0; k < 2; k++) begin
            int sz;
            bit irm, ix, ox;
            sz  = mq[k].size();
            irm = (k == 1) ? (sz < 2) : (sz == 0 || ordy);
            ix  = iv && irm;
            ox  = (sz > 0) && ordy;
            if (rst) begin
                mq[k].delete();
                mcnt[k] = 0;
            end else begin
                if (ox) void'(mq[k].pop_front());
                if (fl) mq[k].delete();
                else if (ix) mq[k].push_back({c, d});
                if (clr) mcnt[k] = 0;
                else if (sz > 0 && !ordy && mcnt[k] < cmax[k]) mcnt[k]++;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        if (mon) mcheck();
    endtask

    task automatic adv();
        @(posedge clk);
        mupdate();
        #1;
    endtask

    initial begin
        cmax[0] = 15;
        cmax[1] = 65535;
        mcnt[0] = 0;
        mcnt[1] = 0;
        //            rst fl clr iv  d      c      ordy chk ov od    oc     ir cnt dchk
        tbl[0]  = mk(1, 0, 0, 0, 64'h0, 8'h00, 0,   0,  0, 64'h0, 8'h00, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  0, 64'h0, 8'h00, 1, 0, 1);
        tbl[2]  = mk(0, 0, 0, 1, 64'h1, 8'hA1, 0,   1,  0, 64'h0, 8'h00, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 64'h2, 8'hA2, 0,   1,  1, 64'h1, 8'hA1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h1, 8'hA1, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h1, 8'hA1, 0, 2, 0);
        tbl[6]  = mk(0, 0, 0, 0, 64'h0, 8'h00, 1,   1,  1, 64'h1, 8'hA1, 0, 3, 0);
        tbl[7]  = mk(0, 0, 0, 0, 64'h0, 8'h00, 1,   1,  1, 64'h2, 8'hA2, 1, 3, 0);
        tbl[8]  = mk(0, 0, 0, 0, 64'h0, 8'h00, 1,   1,  0, 64'h0, 8'h00, 1, 3, 0);
        tbl[9]  = mk(0, 0, 1, 1, 64'h3, 8'h33, 0,   1,  0, 64'h0, 8'h00, 1, 3, 0);
        tbl[10] = mk(0, 0, 0, 1, 64'h4, 8'h44, 0,   1,  1, 64'h3, 8'h33, 1, 0, 0);
        tbl[11] = mk(0, 1, 0, 1, 64'h5, 8'hFF, 0,   1,  1, 64'h3, 8'h33, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 64'h0, 8'h00, 1,   1,  0, 64'h3, 8'h00, 1, 2, 1);
        tbl[13] = mk(0, 0, 1, 1, 64'h6, 8'h66, 0,   1,  0, 64'h3, 8'h00, 1, 2, 1);
        tbl[14] = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h6, 8'h66, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h6, 8'h66, 1, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h6, 8'h66, 1, 2, 0);
        tbl[17] = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h6, 8'h66, 1, 3, 0);
        tbl[18] = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h6, 8'h66, 1, 4, 0);
        tbl[19] = mk(0, 0, 1, 0, 64'h0, 8'h00, 0,   1,  1, 64'h6, 8'h66, 1, 5, 0);
        tbl[20] = mk(0, 0, 0, 0, 64'h0, 8'h00, 0,   1,  1, 64'h6, 8'h66, 1, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 64'h7, 8'h77, 0,   1,  1, 64'h6, 8'h66, 1, 1, 0);
        tbl[22] = mk(1, 1, 1, 1, 64'h8, 8'h88, 0,   1,  1, 64'h6, 8'h66, 0, 2, 0);
        tbl[23] = mk(0, 0, 0, 0, 64'h0, 8'h00, 1,   1,  0, 64'h0, 8'h00, 1, 0, 1);
        tbl[24] = mk(0, 0, 0, 0, 64'h0, 8'h00, 1,   1,  0, 64'h0, 8'h00, 1, 0, 0);

        // Directed table on the skid variant; the model also watches both DUTs.
        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst; fl = tbl[i].fl; clr = tbl[i].clr; iv = tbl[i].iv;
            d = tbl[i].d; c = tbl[i].c; ordy = tbl[i].ordy;
            half();
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_out_valid", i), {63'h0, ov1}, {63'h0, tbl[i].ov});
                chk($sformatf("tbl%0d_in_ready", i), {63'h0, ir1}, {63'h0, tbl[i].ir});
                chk($sformatf("tbl%0d_out_ctrl", i), {56'h0, oc1}, {56'h0, tbl[i].oc});
                chk($sformatf("tbl%0d_stall_cnt", i), {48'h0, cnt1}, {48'h0, tbl[i].cnt});
                if (tbl[i].ov || tbl[i].dchk)
                    chk($sformatf("tbl%0d_out_data", i), od1, tbl[i].od);
            end
            adv();
            mon = 1'b1;
        end
        rst = 1'b0; fl = 1'b0; clr = 1'b0;

        // Streaming 0x10..0x1F with out_ready high: one-cycle latency, in_ready stays 1.
        for (int i = 0; i < 17; i++) begin
            iv = (i < 16); d = 64'h10 + 64'(i); c = 8'(i); ordy = 1'b1;
            half();
            chk("stream_in_ready", {63'h0, ir1}, 64'h1);
            if (i > 0) begin
                chk("stream_out_valid", {63'h0, ov1}, 64'h1);
                chk("stream_out_data", od1, 64'h10 + 64'(i - 1));
            end
            adv();
        end
        iv = 1'b0;
        half(); adv();

        // Saturation: 20 stall cycles on both widths.
        clr = 1'b1; iv = 1'b1; d = 64'h99; c = 8'h99; ordy = 1'b0;
        half(); adv();
        clr = 1'b0; iv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            half(); adv();
        end
        half();
        chk("sat_cnt4", {60'h0, cnt0}, 64'd15);
        chk("sat_cnt16", {48'h0, cnt1}, 64'd20);
        adv();
        ordy = 1'b1;
        half(); adv();
        half(); adv();

        // Continuous input with out_ready toggling every cycle.
        for (int i = 0; i < 40; i++) begin
            iv = 1'b1; d = 64'h200 + 64'(i); c = 8'(i + 1); ordy = i[0];
            half(); adv();
        end

        // Randomized traffic including flush, stall_clr and occasional reset.
        for (int i = 0; i < 800; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            d    = {$urandom, $urandom};
            c    = 8'($urandom);
            half(); adv();
        end
        rst = 1'b0; fl = 1'b0; clr = 1'b0; iv = 1'b0; ordy = 1'b1;
        half(); adv();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
